// File: rtl/if_prefetch_pkg.sv
// Shared defaults and types for the instruction-fetch prefetch queue.
// The fetch-side defaults (W_ADDR, RESET_PC, STEP) live here so every user agrees on them.
package if_prefetch_pkg;

    localparam int unsigned W_ADDR   = 32;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int unsigned STEP     = 4;

    // RQ_STALE: a request is held on the bus, but a redirect arrived after it was issued.
    typedef enum logic [1:0] {
        RQ_OFF,
        RQ_FREE,
        RQ_HELD,
        RQ_STALE
    } req_state_t;

endpackage

// File: rtl/if_fetch_queue.sv
// In-order fetch entry storage: allocate at the tail, fill the oldest unfilled entry,
// and pop at the head. A flush empties the whole queue.
module if_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_inst,
    output logic [CNT_W-1:0]  alloc_cnt,
    output logic [CNT_W-1:0]  unfilled_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic              do_alloc;
    logic              do_fill;
    logic              do_pop;

    assign do_alloc   = alloc && (alloc_cnt != CNT_W'(DEPTH));
    assign do_fill    = fill && (unfilled_cnt != '0);
    assign do_pop     = pop && head_valid;
    assign head_valid = (alloc_cnt != '0) && filled_q[head_ptr];
    assign head_pc    = head_valid ? pc_q[head_ptr] : '0;
    assign head_inst  = head_valid ? inst_q[head_ptr] : '0;

    // Head, fill and tail indices never collide on the same cycle:
    // a full queue blocks allocation, and an empty queue has nothing to fill or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            fill_ptr     <= '0;
            filled_q     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            fill_ptr     <= '0;
            filled_q     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else begin
            if (do_alloc) begin
                pc_q[tail_ptr]     <= alloc_pc;
                filled_q[tail_ptr] <= 1'b0;
                tail_ptr           <= tail_ptr + 1'b1;
            end
            if (do_fill) begin
                inst_q[fill_ptr]   <= fill_data;
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            if (do_pop) begin
                filled_q[head_ptr] <= 1'b0;
                head_ptr           <= head_ptr + 1'b1;
            end
            alloc_cnt    <= alloc_cnt + CNT_W'(do_alloc) - CNT_W'(do_pop);
            unfilled_cnt <= unfilled_cnt + CNT_W'(do_alloc) - CNT_W'(do_fill);
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch front end: issues in-order fetch requests, queues the responses,
// and on a redirect flushes the queue and discards any responses still in flight.
module if_prefetch #(
    parameter int unsigned       ADDR_W   = if_prefetch_pkg::W_ADDR,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(if_prefetch_pkg::RESET_PC),
    parameter int unsigned       STEP     = if_prefetch_pkg::STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              except,
    input  logic [ADDR_W-1:0] except_addr,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst
);
    import if_prefetch_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    req_state_t        state;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  alloc_cnt;
    logic [CNT_W-1:0]  unfilled_cnt;
    logic [CNT_W-1:0]  disc_cnt;
    logic [CNT_W-1:0]  disc_nxt;
    logic              redirect;
    logic              held;
    logic              stale;
    logic              room;
    logic              accept;
    logic              discard_acc;
    logic              alloc;
    logic              drop;
    logic              fill;
    logic              pop;
    logic              hold_now;

    assign redirect    = except | branch;
    assign target      = except ? except_addr : branch_addr;
    assign stale       = (state == RQ_STALE);
    assign held        = (state == RQ_HELD) || stale;
    assign room        = (alloc_cnt + disc_cnt) < CNT_W'(DEPTH);
    assign inst_req    = held || ((state == RQ_FREE) && room);
    assign inst_addr   = fpc;
    assign accept      = inst_req && inst_addr_ok;
    assign hold_now    = inst_req && !inst_addr_ok;
    assign discard_acc = accept && (redirect || stale);
    assign alloc       = accept && !discard_acc;
    assign drop        = inst_data_ok && (disc_cnt != '0);
    assign fill        = inst_data_ok && (disc_cnt == '0) && !redirect;
    assign pop         = out_valid && !stall && !redirect;

    // A same-cycle response retires one outstanding request either way: it would
    // have dropped a discard or filled an entry that is now being flushed.
    always_comb begin
        disc_nxt = disc_cnt;
        if (redirect) begin
            disc_nxt = disc_cnt + unfilled_cnt;
            if (inst_data_ok && (disc_nxt != '0)) begin
                disc_nxt = disc_nxt - 1'b1;
            end
        end else if (drop) begin
            disc_nxt = disc_cnt - 1'b1;
        end
        disc_nxt = disc_nxt + CNT_W'(discard_acc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RQ_OFF;
            fpc      <= RESET_PC;
            redir_pc <= '0;
            disc_cnt <= '0;
        end else begin
            disc_cnt <= disc_nxt;
            if (state == RQ_OFF) begin
                state <= RQ_FREE;
            end else if (hold_now) begin
                state <= (redirect || stale) ? RQ_STALE : RQ_HELD;
            end else begin
                state <= RQ_FREE;
            end
            // While a request is held, the bus address must not move; park the target.
            if (redirect && hold_now) begin
                redir_pc <= target;
            end
            if (redirect && !hold_now) begin
                fpc <= target;
            end else if (accept) begin
                fpc <= stale ? redir_pc : fpc + ADDR_W'(STEP);
            end
        end
    end

    if_fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect),
        .alloc        (alloc),
        .alloc_pc     (fpc),
        .fill         (fill),
        .fill_data    (inst_rdata),
        .pop          (pop),
        .head_valid   (out_valid),
        .head_pc      (out_pc),
        .head_inst    (out_inst),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a simple in-order memory answers one cycle after accept
// with data = ~address, so every expected PC/instruction pair is known up front.
module tb_if_prefetch;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        except;
    logic [31:0] except_addr;
    logic        branch;
    logic [31:0] branch_addr;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          tests = 0;
    int          fails = 0;
    bit          ok_en;
    bit          resp_en;
    int unsigned acc_cnt;
    logic [31:0] mem_q[$];

    always #5 clk = ~clk;

    if_prefetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'hBFC0_0000),
        .STEP     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .except       (except),
        .except_addr  (except_addr),
        .branch       (branch),
        .branch_addr  (branch_addr),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive this cycle's memory handshake, then advance to the next negedge.
    task automatic tick();
        inst_data_ok = 1'b0;
        if (resp_en && mem_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = ~mem_q.pop_front();
        end
        inst_addr_ok = ok_en && inst_req;
        if (inst_addr_ok) begin
            mem_q.push_back(inst_addr);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        stall        = 1'b0;
        except       = 1'b0;
        branch       = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        ok_en        = 1'b0;
        resp_en      = 1'b1;
        acc_cnt      = 0;
        mem_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        for (int n = 0; n < 20 && out_valid !== 1'b1; n++) tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, exp_pc);
        chk({tag, "_inst"}, out_inst, ~exp_pc);
    endtask

    initial begin
        rst          = 1'b0;
        stall        = 1'b0;
        except       = 1'b0;
        branch       = 1'b0;
        except_addr  = '0;
        branch_addr  = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        ok_en        = 1'b0;
        resp_en      = 1'b1;
        acc_cnt      = 0;
        repeat (2) @(negedge clk);

        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", inst_addr, BASE);

        rst = 1'b1;
        @(negedge clk);
        chk("rel_req", 32'(inst_req), 32'd1);

        // Back-to-back fetch with an always-ready memory.
        ok_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk("seq_addr", inst_addr, BASE + 32'(4 * c));
            if (c == 1) chk("seq_latency", 32'(out_valid), 32'd0);
            if (c >= 2) begin
                chk("seq_pc", out_pc, BASE + 32'(4 * (c - 2)));
                chk("seq_inst", out_inst, ~(BASE + 32'(4 * (c - 2))));
            end
            tick();
        end

        // Stalled decode: the queue fills to DEPTH and requests stop.
        do_reset();
        stall = 1'b1;
        ok_en = 1'b1;
        repeat (10) tick();
        chk("stall_acc", acc_cnt, 32'd4);
        chk("full_req", 32'(inst_req), 32'd0);
        chk("stall_pc", out_pc, BASE);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        chk("pop_pc", out_pc, BASE + 32'd4);
        chk("pop_req", 32'(inst_req), 32'd1);
        chk("pop_addr", inst_addr, BASE + 32'd16);
        tick();
        tick();
        chk("pop_acc", acc_cnt, 32'd5);
        chk("refull_req", 32'(inst_req), 32'd0);

        // Branch with responses still outstanding.
        do_reset();
        ok_en   = 1'b1;
        resp_en = 1'b0;
        tick();
        tick();
        chk("br_pre_addr", inst_addr, BASE + 32'd8);
        branch      = 1'b1;
        branch_addr = 32'h8000_1000;
        tick();
        branch = 1'b0;
        chk("br_flush", 32'(out_valid), 32'd0);
        chk("br_addr", inst_addr, 32'h8000_1000);
        resp_en = 1'b1;
        wait_valid("br", 32'h8000_1000);

        // Exception and branch together: exception target wins.
        do_reset();
        ok_en = 1'b1;
        tick();
        except      = 1'b1;
        except_addr = 32'hBFC0_0380;
        branch      = 1'b1;
        branch_addr = 32'h8000_2000;
        tick();
        except = 1'b0;
        branch = 1'b0;
        chk("exc_flush", 32'(out_valid), 32'd0);
        chk("exc_addr", inst_addr, 32'hBFC0_0380);
        wait_valid("exc", 32'hBFC0_0380);

        // Redirect while a request is held on the bus.
        do_reset();
        chk("hold_req0", 32'(inst_req), 32'd1);
        tick();
        chk("hold_addr0", inst_addr, BASE);
        branch      = 1'b1;
        branch_addr = 32'h8000_1000;
        tick();
        branch = 1'b0;
        chk("hold_addr1", inst_addr, BASE);
        chk("hold_req1", 32'(inst_req), 32'd1);
        tick();
        chk("hold_addr2", inst_addr, BASE);
        ok_en = 1'b1;
        tick();
        chk("hold_acc", acc_cnt, 32'd1);
        chk("hold_next", inst_addr, 32'h8000_1000);
        wait_valid("hold", 32'h8000_1000);

        // Asynchronous reset with entries queued.
        do_reset();
        ok_en = 1'b1;
        stall = 1'b1;
        repeat (3) tick();
        chk("pre_valid", 32'(out_valid), 32'd1);
        chk("pre_req", 32'(inst_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_req", 32'(inst_req), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        do_reset();
        chk("arst_addr", inst_addr, BASE);
        chk("arst_req1", 32'(inst_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
